// File: rtl/quad_encoder_dec.sv
// Rotary encoder front end for one encoder channel: pin synchronisers, glitch filters, x4
// quadrature decode into a detent-scaled position count, and push-switch debounce with press detect.
module quad_encoder_dec #(
  parameter int unsigned FILT_LEN = 4,
  parameter int unsigned SW_LEN   = 16,
  parameter int unsigned STEPS    = 4,
  parameter int unsigned CNT_W    = 8,
  parameter int unsigned CNT_MAX  = 99,
  parameter int unsigned WRAP     = 1
) (
  input  logic             clk_25MHz,
  input  logic             reset,
  input  logic [1:0]       enc,
  input  logic             enc_sw,
  input  logic             clr,
  output logic [CNT_W-1:0] count,
  output logic             step_up,
  output logic             step_dn,
  output logic             enc_err,
  output logic             sw_level,
  output logic             sw_press
);

  localparam int unsigned SwCntW = $clog2(SW_LEN + 1);
  localparam int unsigned AccW   = $clog2(STEPS) + 2;

  localparam logic [2:0]             QLast  = 3'(FILT_LEN - 1);
  localparam logic [SwCntW-1:0]      SwLast = SwCntW'(SW_LEN - 1);
  localparam logic signed [AccW-1:0] AccMax = AccW'(STEPS - 1);
  localparam logic signed [AccW-1:0] AccMin = -AccMax;
  localparam logic [CNT_W-1:0]       CntMax = CNT_W'(CNT_MAX);

  // Quadrature path
  logic [1:0] q_s1_q, q_s2_q, q_s3_q;
  logic [1:0] qf_q, qf_d;
  logic [1:0] qp_q;
  logic [2:0] q_cnt_q, q_cnt_d;

  // Switch path
  logic              sw_s1_q, sw_s2_q, sw_s3_q;
  logic              swf_q, swf_d;
  logic [SwCntW-1:0] sw_cnt_q, sw_cnt_d;
  logic              sw_press_q, sw_press_d;

  // Position tracking
  logic signed [AccW-1:0] acc_q, acc_d;
  logic [CNT_W-1:0]       count_q, count_d;
  logic                   cnt_inc, cnt_dec;

  // q_s3_q holds the previous s2 so a change on s2 restarts the stability count.
  always_comb begin
    qf_d    = qf_q;
    q_cnt_d = q_cnt_q;
    if ((q_s2_q != q_s3_q) || (q_s2_q == qf_q)) begin
      q_cnt_d = '0;
    end else if (q_cnt_q == QLast) begin
      qf_d    = q_s2_q;
      q_cnt_d = '0;
    end else begin
      q_cnt_d = q_cnt_q + 3'd1;
    end
  end

  always_comb begin
    swf_d    = swf_q;
    sw_cnt_d = sw_cnt_q;
    if ((sw_s2_q != sw_s3_q) || (sw_s2_q == swf_q)) begin
      sw_cnt_d = '0;
    end else if (sw_cnt_q == SwLast) begin
      swf_d    = sw_s2_q;
      sw_cnt_d = '0;
    end else begin
      sw_cnt_d = sw_cnt_q + 1'b1;
    end
    // Pin is active-low: a press is the filtered value falling.
    sw_press_d = swf_q & ~swf_d;
  end

  always_comb begin
    step_up = 1'b0;
    step_dn = 1'b0;
    enc_err = 1'b0;
    unique case ({qp_q, qf_q})
      4'b00_01, 4'b01_11, 4'b11_10, 4'b10_00: step_up = 1'b1;
      4'b00_10, 4'b10_11, 4'b11_01, 4'b01_00: step_dn = 1'b1;
      4'b00_11, 4'b11_00, 4'b01_10, 4'b10_01: enc_err = 1'b1;
      default: ;
    endcase
  end

  always_comb begin
    acc_d   = acc_q;
    cnt_inc = 1'b0;
    cnt_dec = 1'b0;
    if (step_up) begin
      if (acc_q == AccMax) begin
        acc_d   = '0;
        cnt_inc = 1'b1;
      end else begin
        acc_d = acc_q + AccW'(1);
      end
    end else if (step_dn) begin
      if (acc_q == AccMin) begin
        acc_d   = '0;
        cnt_dec = 1'b1;
      end else begin
        acc_d = acc_q - AccW'(1);
      end
    end
    if (clr) begin
      acc_d = '0;
    end
  end

  always_comb begin
    count_d = count_q;
    if (cnt_inc) begin
      if (count_q != CntMax) begin
        count_d = count_q + 1'b1;
      end else if (WRAP != 0) begin
        count_d = '0;
      end
    end else if (cnt_dec) begin
      if (count_q != '0) begin
        count_d = count_q - 1'b1;
      end else if (WRAP != 0) begin
        count_d = CntMax;
      end
    end
    if (clr) begin
      count_d = '0;
    end
  end

  always_ff @(posedge clk_25MHz) begin
    if (reset) begin
      q_s1_q     <= 2'b11;
      q_s2_q     <= 2'b11;
      q_s3_q     <= 2'b11;
      qf_q       <= 2'b11;
      qp_q       <= 2'b11;
      q_cnt_q    <= '0;
      sw_s1_q    <= 1'b1;
      sw_s2_q    <= 1'b1;
      sw_s3_q    <= 1'b1;
      swf_q      <= 1'b1;
      sw_cnt_q   <= '0;
      sw_press_q <= 1'b0;
      acc_q      <= '0;
      count_q    <= '0;
    end else begin
      q_s1_q     <= enc;
      q_s2_q     <= q_s1_q;
      q_s3_q     <= q_s2_q;
      qf_q       <= qf_d;
      qp_q       <= qf_q;
      q_cnt_q    <= q_cnt_d;
      sw_s1_q    <= enc_sw;
      sw_s2_q    <= sw_s1_q;
      sw_s3_q    <= sw_s2_q;
      swf_q      <= swf_d;
      sw_cnt_q   <= sw_cnt_d;
      sw_press_q <= sw_press_d;
      acc_q      <= acc_d;
      count_q    <= count_d;
    end
  end

  assign count    = count_q;
  assign sw_level = ~swf_q;
  assign sw_press = sw_press_q;

endmodule

// File: tb/tb_quad_encoder_dec.sv
`timescale 1ns/1ps
// Bench for quad_encoder_dec: vector table, directed corner sequences and a randomized run
// checked every cycle against a sample-window reference model (wrapping and saturating DUTs).
module tb_quad_encoder_dec;
  localparam int FILT_LEN = 4;
  localparam int SW_LEN   = 16;
  localparam int STEPS    = 4;
  localparam int CNT_W    = 8;
  localparam int CNT_MAX  = 99;
  localparam int QDEPTH   = FILT_LEN + 3;
  localparam int SDEPTH   = SW_LEN + 3;

  logic             clk    = 1'b0;
  logic             reset  = 1'b1;
  logic [1:0]       enc    = 2'b11;
  logic             enc_sw = 1'b1;
  logic             clr    = 1'b0;
  logic [CNT_W-1:0] count_w, count_s;
  logic             up_w, dn_w, err_w, lvl_w, prs_w;
  logic             up_s, dn_s, err_s, lvl_s, prs_s;

  int n_cmp  = 0;
  int n_fail = 0;

  always #20 clk = ~clk;

  quad_encoder_dec #(
    .FILT_LEN(FILT_LEN), .SW_LEN(SW_LEN), .STEPS(STEPS),
    .CNT_W(CNT_W), .CNT_MAX(CNT_MAX), .WRAP(1)
  ) dut_wrap (
    .clk_25MHz(clk), .reset(reset), .enc(enc), .enc_sw(enc_sw), .clr(clr),
    .count(count_w), .step_up(up_w), .step_dn(dn_w), .enc_err(err_w),
    .sw_level(lvl_w), .sw_press(prs_w)
  );

  quad_encoder_dec #(
    .FILT_LEN(FILT_LEN), .SW_LEN(SW_LEN), .STEPS(STEPS),
    .CNT_W(CNT_W), .CNT_MAX(CNT_MAX), .WRAP(0)
  ) dut_sat (
    .clk_25MHz(clk), .reset(reset), .enc(enc), .enc_sw(enc_sw), .clr(clr),
    .count(count_s), .step_up(up_s), .step_dn(dn_s), .enc_err(err_s),
    .sw_level(lvl_s), .sw_press(prs_s)
  );

  // Reference model: raw-pin sample windows, quadrature position index, integer sub-step.
  logic [1:0] q_win[$];
  logic       s_win[$];
  logic [1:0] m_qf;
  logic       m_swf;
  int         m_acc, m_cnt_w, m_cnt_s;
  logic       m_up, m_dn, m_err, m_press;

  function automatic int pos_of(input logic [1:0] g);
    case (g)
      2'b00:   return 0;
      2'b01:   return 1;
      2'b11:   return 2;
      default: return 3;
    endcase
  endfunction

  function automatic logic [1:0] gray_of(input int p);
    case (p % 4)
      0:       return 2'b00;
      1:       return 2'b01;
      2:       return 2'b11;
      default: return 2'b10;
    endcase
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_step();
    bit   same;
    int   d;
    logic new_swf;
    if (reset) begin
      q_win.delete();
      s_win.delete();
      for (int i = 0; i < QDEPTH; i++) q_win.push_back(2'b11);
      for (int i = 0; i < SDEPTH; i++) s_win.push_back(1'b1);
      m_qf = 2'b11; m_swf = 1'b1;
      m_acc = 0; m_cnt_w = 0; m_cnt_s = 0;
      m_up = 1'b0; m_dn = 1'b0; m_err = 1'b0; m_press = 1'b0;
      return;
    end
    if (m_up || m_dn) begin
      m_acc += m_up ? 1 : -1;
      if (m_acc == STEPS) begin
        m_acc   = 0;
        m_cnt_w = (m_cnt_w + 1) % (CNT_MAX + 1);
        if (m_cnt_s < CNT_MAX) m_cnt_s++;
      end else if (m_acc == -STEPS) begin
        m_acc   = 0;
        m_cnt_w = (m_cnt_w + CNT_MAX) % (CNT_MAX + 1);
        if (m_cnt_s > 0) m_cnt_s--;
      end
    end
    if (clr) begin
      m_acc = 0; m_cnt_w = 0; m_cnt_s = 0;
    end
    q_win.push_back(enc);
    void'(q_win.pop_front());
    m_up = 1'b0; m_dn = 1'b0; m_err = 1'b0;
    same = 1'b1;
    for (int i = 1; i <= FILT_LEN; i++) if (q_win[i] != q_win[0]) same = 1'b0;
    if (same && (q_win[0] != m_qf)) begin
      d     = (pos_of(q_win[0]) - pos_of(m_qf) + 4) % 4;
      m_up  = (d == 1);
      m_dn  = (d == 3);
      m_err = (d == 2);
      m_qf  = q_win[0];
    end
    s_win.push_back(enc_sw);
    void'(s_win.pop_front());
    same = 1'b1;
    for (int i = 1; i <= SW_LEN; i++) if (s_win[i] != s_win[0]) same = 1'b0;
    new_swf = (same && (s_win[0] != m_swf)) ? s_win[0] : m_swf;
    m_press = m_swf && !new_swf;
    m_swf   = new_swf;
  endtask

  task automatic tick();
    @(posedge clk);
    model_step();
    @(negedge clk);
    check("model", {count_w, count_s, up_w, dn_w, err_w, lvl_w, prs_w,
                    up_s, dn_s, err_s, lvl_s, prs_s},
                   {CNT_W'(m_cnt_w), CNT_W'(m_cnt_s), m_up, m_dn, m_err, ~m_swf, m_press,
                    m_up, m_dn, m_err, ~m_swf, m_press});
  endtask

  task automatic hold(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic detents(input int n, input bit fwd);
    for (int i = 0; i < n * STEPS; i++) begin
      enc = gray_of(pos_of(enc) + (fwd ? 1 : 3));
      hold(6);
    end
    hold(8);
  endtask

  // sel: 0 = step_up, 1 = step_dn, 2 = sw_press; lat = -1 if the bound expires
  task automatic wait_for(input string name, input int sel, input int want, output int lat);
    logic hit;
    lat = -1;
    for (int k = 1; k <= 40; k++) begin
      tick();
      hit = (sel == 0) ? up_w : (sel == 1) ? dn_w : prs_w;
      if (hit) begin
        lat = k;
        break;
      end
    end
    check(name, lat, want);
  endtask

  typedef struct {
    logic [1:0] enc;
    logic       clr;
    int         hold;
    int         cnt;
    int         up;
    int         dn;
    int         err;
  } vec_t;

  vec_t vecs[$];

  function automatic void add(input logic [1:0] e, input logic c, input int h, input int cnt,
                              input int u, input int dd, input int er);
    vec_t v;
    v.enc = e; v.clr = c; v.hold = h; v.cnt = cnt; v.up = u; v.dn = dd; v.err = er;
    vecs.push_back(v);
  endfunction

  initial begin
    int n_up, n_dn, n_err, lat, presses, eh, sh, r;

    // Forward detent, reverse detent, glitch, illegal jumps, unwind, clr of partial detent
    add(2'b10, 0, 10, 0, 1, 0, 0); add(2'b00, 0, 10, 0, 1, 0, 0);
    add(2'b01, 0, 10, 0, 1, 0, 0); add(2'b11, 0, 10, 1, 1, 0, 0);
    add(2'b01, 0, 10, 1, 0, 1, 0); add(2'b00, 0, 10, 1, 0, 1, 0);
    add(2'b10, 0, 10, 1, 0, 1, 0); add(2'b11, 0, 10, 0, 0, 1, 0);
    add(2'b10, 0, 3,  0, 0, 0, 0); add(2'b11, 0, 10, 0, 0, 0, 0);
    add(2'b00, 0, 10, 0, 0, 0, 1); add(2'b11, 0, 10, 0, 0, 0, 1);
    add(2'b10, 0, 10, 0, 1, 0, 0); add(2'b00, 0, 10, 0, 1, 0, 0);
    add(2'b01, 0, 10, 0, 1, 0, 0); add(2'b00, 0, 10, 0, 0, 1, 0);
    add(2'b10, 0, 10, 0, 0, 1, 0); add(2'b11, 0, 10, 0, 0, 1, 0);
    add(2'b10, 0, 10, 0, 1, 0, 0); add(2'b00, 0, 10, 0, 1, 0, 0);
    add(2'b01, 0, 10, 0, 1, 0, 0); add(2'b11, 0, 10, 1, 1, 0, 0);
    add(2'b10, 0, 10, 1, 1, 0, 0); add(2'b00, 0, 10, 1, 1, 0, 0);
    add(2'b01, 0, 10, 1, 1, 0, 0); add(2'b01, 1, 3,  0, 0, 0, 0);
    add(2'b11, 0, 10, 0, 1, 0, 0); add(2'b10, 0, 10, 0, 1, 0, 0);
    add(2'b00, 0, 10, 0, 1, 0, 0); add(2'b01, 0, 10, 1, 1, 0, 0);

    // Reset state
    hold(5);
    check("rst_count_wrap", count_w, 0);
    check("rst_count_sat", count_s, 0);
    check("rst_pulses", {up_w, dn_w, err_w, prs_w}, 4'b0000);
    check("rst_sw_level", lvl_w, 0);
    reset = 1'b0;
    hold(10);

    foreach (vecs[i]) begin
      enc = vecs[i].enc;
      clr = vecs[i].clr;
      n_up = 0; n_dn = 0; n_err = 0;
      for (int k = 0; k < vecs[i].hold; k++) begin
        tick();
        n_up += int'(up_w); n_dn += int'(dn_w); n_err += int'(err_w);
      end
      clr = 1'b0;
      check($sformatf("vec%0d_count", i), count_w, vecs[i].cnt);
      check($sformatf("vec%0d_up", i), n_up, vecs[i].up);
      check($sformatf("vec%0d_dn", i), n_dn, vecs[i].dn);
      check($sformatf("vec%0d_err", i), n_err, vecs[i].err);
    end

    // Reset mid-detent (acc=2 at count 1) discards the partial detent
    enc = 2'b11; hold(10);
    enc = 2'b10; hold(10);
    reset = 1'b1; enc = 2'b11; hold(5);
    reset = 1'b0; hold(10);
    check("midrst_count", count_w, 0);
    enc = 2'b10; hold(10);
    enc = 2'b00; hold(10);
    enc = 2'b01; hold(10);
    check("midrst_3steps", count_w, 0);
    enc = 2'b11; hold(10);
    check("midrst_4steps", count_w, 1);

    // Pin change to pulse latency
    enc = 2'b10; wait_for("lat_up", 0, 3 + FILT_LEN, lat); hold(10);
    enc = 2'b11; wait_for("lat_dn", 1, 3 + FILT_LEN, lat); hold(10);

    // clr on the edge of the 4th forward step at count 5
    detents(4, 1'b1);
    check("pre_clr_count", count_w, 5);
    enc = 2'b10; hold(10);
    enc = 2'b00; hold(10);
    enc = 2'b01; hold(10);
    enc = 2'b11; wait_for("clr_step_lat", 0, 3 + FILT_LEN, lat);
    check("clr_step_up", up_w, 1);
    clr = 1'b1; tick(); clr = 1'b0;
    check("clr_count_wrap", count_w, 0);
    check("clr_count_sat", count_s, 0);
    detents(1, 1'b1);
    check("post_clr_detent", count_w, 1);

    // Bouncing press then bouncing release
    presses = 0;
    for (int i = 0; i < 6; i++) begin
      enc_sw = (i % 2 == 0) ? 1'b0 : 1'b1;
      for (int j = 0; j < 2; j++) begin tick(); presses += int'(prs_w); end
    end
    enc_sw = 1'b0; lat = -1;
    for (int k = 1; k <= 30; k++) begin
      tick();
      if (prs_w) begin presses++; if (lat < 0) lat = k; end
    end
    check("sw_press_count", presses, 1);
    check("sw_press_lat", lat, SW_LEN + 3);
    check("sw_level_on", lvl_w, 1);
    presses = 0;
    for (int i = 0; i < 6; i++) begin
      enc_sw = (i % 2 == 0) ? 1'b1 : 1'b0;
      for (int j = 0; j < 2; j++) begin tick(); presses += int'(prs_w); end
    end
    enc_sw = 1'b1;
    for (int k = 0; k < 30; k++) begin tick(); presses += int'(prs_w); end
    check("sw_release_pulses", presses, 0);
    check("sw_level_off", lvl_w, 0);

    // Step pulse and press on the same cycle
    enc_sw = 1'b0; hold(12);
    enc = 2'b10; hold(6);
    tick();
    check("coinc_step_press", {up_w, prs_w}, 2'b11);
    enc_sw = 1'b1; hold(30);

    // Count limits for both wrap and saturate
    reset = 1'b1; enc = 2'b11; hold(3); reset = 1'b0; hold(5);
    detents(1, 1'b0);
    check("dec0_wrap", count_w, CNT_MAX); check("dec0_sat", count_s, 0);
    detents(1, 1'b1);
    check("inc_wrap", count_w, 0); check("inc_sat", count_s, 1);
    detents(98, 1'b1);
    check("run_wrap", count_w, 98); check("run_sat", count_s, CNT_MAX);
    detents(1, 1'b1);
    check("top_wrap", count_w, CNT_MAX); check("top_sat_hold", count_s, CNT_MAX);
    detents(1, 1'b1);
    check("incmax_wrap", count_w, 0); check("incmax_sat", count_s, CNT_MAX);

    // Randomized run against the model
    eh = 1; sh = 1;
    for (int c = 0; c < 4000; c++) begin
      eh--;
      if (eh == 0) begin
        r = int'($urandom_range(0, 9));
        if (r < 4)      enc = gray_of(pos_of(enc) + 1);
        else if (r < 7) enc = gray_of(pos_of(enc) + 3);
        else if (r < 8) enc = ~enc;
        eh = int'($urandom_range(1, 12));
      end
      sh--;
      if (sh == 0) begin
        enc_sw = 1'($urandom_range(0, 1));
        sh = int'($urandom_range(1, 30));
      end
      clr   = ($urandom_range(0, 99) == 0);
      reset = ($urandom_range(0, 1499) == 0);
      tick();
    end
    reset = 1'b0; clr = 1'b0;
    hold(5);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
